// File: rtl/trng_uart_rx.sv
// 8N1 UART receiver with a single-entry holding register and RTS flow control.
// Bits are sampled mid-bit, timed from the synchronized falling edge of the start bit.
module trng_uart_rx #(
    parameter int unsigned CLK_PER_BIT = 833
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_serial_data,
    output logic       o_serial_rts_n,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam logic [15:0] BIT_LAST  = 16'(CLK_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'((CLK_PER_BIT / 2) - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;
    logic        stop_good_s;
    logic        rx_s;

    assign rx_s = sync2_q;

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= i_serial_data;
            sync2_q <= sync1_q;
        end
    end

    // Frame FSM, bit timing and holding-register next-state logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q & ~i_ready;
        ferr_d      = 1'b0;
        ovr_d       = 1'b0;
        stop_good_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = HALF_LAST;
                    bit_d   = 3'd0;
                end else begin
                    cnt_d   = 16'd0;
                end
            end
            START: begin
                if (cnt_q == 16'd0) begin
                    cnt_d = BIT_LAST;
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == 16'd0) begin
                    shift_d[bit_q] = rx_s;
                    cnt_d          = BIT_LAST;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == 16'd0) begin
                    cnt_d = 16'd0;
                    if (rx_s) begin
                        state_d     = IDLE;
                        stop_good_s = 1'b1;
                    end else begin
                        state_d = WAIT_IDLE;
                        ferr_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            WAIT_IDLE: begin
                // A held-low line reports one framing error, not one per frame time.
                if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase

        // A slot frees up either when empty or when it is being accepted this cycle.
        if (stop_good_s) begin
            if (!valid_q || i_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else begin
            ovr_d = 1'b0;
        end
    end

    // State, counters, holding register and status pulses.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_data         = data_q;
    assign o_valid        = valid_q;
    assign o_serial_rts_n = valid_q;
    assign o_frame_err    = ferr_q;
    assign o_overrun      = ovr_q;

endmodule

// File: tb/tb_trng_uart_rx.sv
// Self-checking bench for trng_uart_rx at CLK_PER_BIT=8: directed scenarios plus
// random byte streams checked against an expected-byte queue.
module tb_trng_uart_rx;

    localparam int CPB     = 8;
    localparam int HALF    = CPB / 2;
    localparam int LATENCY = 3 + HALF + 9 * CPB;

    logic       clk;
    logic       i_reset_n;
    logic       i_serial_data;
    logic       o_serial_rts_n;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_frame_err;
    logic       o_overrun;

    int checks   = 0;
    int failures = 0;

    logic [7:0] got_q[$];
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;

    trng_uart_rx #(.CLK_PER_BIT(CPB)) dut (
        .i_clk          (clk),
        .i_reset_n      (i_reset_n),
        .i_serial_data  (i_serial_data),
        .o_serial_rts_n (o_serial_rts_n),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_frame_err    (o_frame_err),
        .o_overrun      (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records every accepted byte and every status pulse.
    always @(negedge clk) begin
        if (o_valid && i_ready) got_q.push_back(o_data);
        if (o_frame_err) ferr_cnt <= ferr_cnt + 1;
        if (o_overrun)   ovr_cnt  <= ovr_cnt + 1;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        i_serial_data = 1'b0;
        idle(CPB);
        for (int k = 0; k < 8; k++) begin
            i_serial_data = b[k];
            idle(CPB);
        end
        i_serial_data = stop;
        idle(CPB);
    endtask

    task automatic test_reset;
        i_reset_n = 1'b0; i_serial_data = 1'b1; i_ready = 1'b1;
        idle(3);
        checks++;
        if (o_valid !== 1'b0 || o_data !== 8'h00 || o_serial_rts_n !== 1'b0 ||
            o_frame_err !== 1'b0 || o_overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: valid=%b data=%h rts_n=%b ferr=%b ovr=%b required 0 00 0 0 0",
                     o_valid, o_data, o_serial_rts_n, o_frame_err, o_overrun);
        end
        i_reset_n = 1'b1;
        idle(10);
        checks++;
        if (o_valid !== 1'b0 || ferr_cnt !== 0 || ovr_cnt !== 0) begin
            failures++;
            $display("FAIL reset_release: valid=%b ferr=%0d ovr=%0d required 0 0 0", o_valid, ferr_cnt, ovr_cnt);
        end
    endtask

    task automatic test_latency;
        int n = 0;
        int base = got_q.size();
        i_ready = 1'b1;
        fork
            drive_frame(8'hA5, 1'b1);
            begin
                while (!o_valid && n < 200) begin
                    @(posedge clk); #1; n++;
                end
                checks++;
                if (n !== LATENCY || o_data !== 8'hA5 || o_serial_rts_n !== 1'b1) begin
                    failures++;
                    $display("FAIL latency_a5: cycles=%0d data=%h rts_n=%b required %0d a5 1",
                             n, o_data, o_serial_rts_n, LATENCY);
                end
                @(posedge clk); #1;
                checks++;
                if (o_valid !== 1'b0 || o_serial_rts_n !== 1'b0) begin
                    failures++;
                    $display("FAIL one_cycle_valid: valid=%b rts_n=%b required 0 0", o_valid, o_serial_rts_n);
                end
            end
        join
        idle(3);
        checks++;
        if (got_q.size() !== base + 1 || got_q[base] !== 8'hA5) begin
            failures++;
            $display("FAIL accept_a5: count=%0d required %0d", got_q.size() - base, 1);
        end
    endtask

    task automatic test_false_start;
        int base = got_q.size();
        int fb = ferr_cnt;
        i_serial_data = 1'b0;
        idle(3);
        i_serial_data = 1'b1;
        idle(40);
        checks++;
        if (got_q.size() !== base || ferr_cnt !== fb || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL false_start: bytes=%0d ferr=%0d valid=%b required 0 0 0",
                     got_q.size() - base, ferr_cnt - fb, o_valid);
        end
        drive_frame(8'h6B, 1'b1);
        idle(5);
        checks++;
        if (got_q.size() !== base + 1 || got_q[base] !== 8'h6B) begin
            failures++;
            $display("FAIL after_false_start: count=%0d required 1 byte 6b", got_q.size() - base);
        end
    endtask

    task automatic test_frame_err;
        int base = got_q.size();
        int fb = ferr_cnt;
        drive_frame(8'h3C, 1'b0);
        idle(40);
        i_serial_data = 1'b1;
        idle(5);
        checks++;
        if (ferr_cnt - fb !== 1 || got_q.size() !== base) begin
            failures++;
            $display("FAIL frame_err: pulses=%0d bytes=%0d required 1 0", ferr_cnt - fb, got_q.size() - base);
        end
        drive_frame(8'h5A, 1'b1);
        idle(5);
        checks++;
        if (got_q.size() !== base + 1 || got_q[base] !== 8'h5A || ferr_cnt - fb !== 1) begin
            failures++;
            $display("FAIL after_frame_err: bytes=%0d pulses=%0d required 1 1", got_q.size() - base, ferr_cnt - fb);
        end
    endtask

    task automatic test_overrun;
        int base = got_q.size();
        int ob = ovr_cnt;
        i_ready = 1'b0;
        drive_frame(8'h11, 1'b1);
        drive_frame(8'h22, 1'b1);
        idle(3);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'h11 || o_serial_rts_n !== 1'b1 || ovr_cnt - ob !== 1) begin
            failures++;
            $display("FAIL overrun_hold: valid=%b data=%h rts_n=%b ovr=%0d required 1 11 1 1",
                     o_valid, o_data, o_serial_rts_n, ovr_cnt - ob);
        end
        i_ready = 1'b1;
        idle(1);
        checks++;
        if (o_valid !== 1'b0 || got_q.size() !== base + 1 || got_q[base] !== 8'h11) begin
            failures++;
            $display("FAIL overrun_drain: valid=%b bytes=%0d required 0 1", o_valid, got_q.size() - base);
        end
    endtask

    task automatic test_ready_same_cycle;
        int base = got_q.size();
        int ob = ovr_cnt;
        i_ready = 1'b0;
        drive_frame(8'h11, 1'b1);
        fork
            drive_frame(8'h22, 1'b1);
            begin
                idle(LATENCY - 1);
                i_ready = 1'b1;
                idle(1);
                i_ready = 1'b0;
                checks++;
                if (o_valid !== 1'b1 || o_data !== 8'h22 || ovr_cnt !== ob) begin
                    failures++;
                    $display("FAIL ready_at_stop: valid=%b data=%h ovr=%0d required 1 22 0",
                             o_valid, o_data, ovr_cnt - ob);
                end
            end
        join
        i_ready = 1'b1;
        idle(3);
        checks++;
        if (got_q.size() !== base + 2 || got_q[base] !== 8'h11 || got_q[base + 1] !== 8'h22) begin
            failures++;
            $display("FAIL ready_at_stop_order: bytes=%0d required 2 (11,22)", got_q.size() - base);
        end
    endtask

    task automatic test_reset_mid;
        int base = got_q.size();
        int fb = ferr_cnt;
        int ob = ovr_cnt;
        i_ready = 1'b0;
        drive_frame(8'h99, 1'b1);
        fork
            drive_frame(8'hFF, 1'b1);
            begin
                idle(5 * CPB + 2);
                i_reset_n = 1'b0;
                #1;
                checks++;
                if (o_valid !== 1'b0 || o_data !== 8'h00 || o_serial_rts_n !== 1'b0 ||
                    o_frame_err !== 1'b0 || o_overrun !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_mid_frame: valid=%b data=%h rts_n=%b required 0 00 0",
                             o_valid, o_data, o_serial_rts_n);
                end
                idle(3);
                i_reset_n = 1'b1;
            end
        join
        idle(30);
        checks++;
        if (o_valid !== 1'b0 || ferr_cnt !== fb || ovr_cnt !== ob) begin
            failures++;
            $display("FAIL reset_no_partial: valid=%b ferr=%0d ovr=%0d required 0 0 0",
                     o_valid, ferr_cnt - fb, ovr_cnt - ob);
        end
        i_ready = 1'b1;
        drive_frame(8'h42, 1'b1);
        idle(3);
        checks++;
        if (got_q.size() !== base + 1 || got_q[base] !== 8'h42) begin
            failures++;
            $display("FAIL reset_resume: bytes=%0d required 1 byte 42", got_q.size() - base);
        end
    endtask

    task automatic test_random;
        logic [7:0] exp_q[$];
        int base = got_q.size();
        i_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            logic [7:0] b;
            int gap;
            b   = 8'($urandom);
            gap = $urandom_range(0, 6);
            exp_q.push_back(b);
            drive_frame(b, 1'b1);
            if (gap > 0) idle(gap);
        end
        idle(5);
        checks++;
        if (got_q.size() - base !== exp_q.size()) begin
            failures++;
            $display("FAIL random_count: got=%0d required %0d", got_q.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[base + i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL random_byte[%0d]: got=%h required %h", i, got_q[base + i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_ready_same_cycle();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
